sensor_prio_selector: RTL and testbench
=======================================

// Module: sensor_prio_selector
// PURPOSE
//  Parametrised, registered successor of the 16-channel sensor/priority command selector.
//  Each of NCH sensors owns a W-bit command channel. The highest-index active sensor
//  selects its channel onto y. Master switch m forces channel 0 (override).
//  A newly selected channel is held for DWELL cycles before re-arbitration, which
//  suppresses chatter from bouncing sensors. Sits between the sensor front-end and
//  the actuator driver; all outputs are registered.
// PARAMETERS
//  NCH    16                 number of sensor/command channels (>=2)
//  W      2                  command width per channel
//  DWELL  4                  minimum cycles a new winner is held (0 = no hold)
//  CW     $clog2(NCH)        derived, selector width (localparam)
// PORTS
//  clk    in   1      clock
//  rst_n  in   1      synchronous reset, active-low
//  en     in   1      1 = advance; 0 = freeze all registers (reset still acts)
//  m      in   1      master override; 1 forces channel 0
//  cmd    in   NCH*W  packed commands; channel k = cmd[k*W+W-1 : k*W]
//  s      in   NCH    sensors; s[k] requests channel k; higher index = higher priority
//  y      out  W      registered selected command
//  sel    out  CW     registered selected channel index
//  valid  out  1      1 when a sensor-selected channel drives y (LOCK/TRACK)
//  ovr    out  1      1 while in OVR state
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous, active-low: rst_n=0 at a rising edge
//    sets state=IDLE, sel=0, cnt=0, y=0, valid=0, ovr=0.
//  - Reset has priority over en. Reset mid-LOCK aborts the hold immediately.
//  - win = index of the highest set bit of s; any = |s.
//  - States: IDLE, LOCK, TRACK, OVR. Evaluated at each rising edge with rst_n=1, en=1.
//  - m=1 (any state, highest priority): state<=OVR, sel<=0, cnt<=0.
//  - IDLE or OVR, m=0:
//    - any=1: sel<=win. If DWELL>0: cnt<=DWELL, state<=LOCK. Else state<=TRACK.
//    - any=0: sel<=0, state<=IDLE.
//  - LOCK, m=0: sel is held regardless of s, including sensor drop or a higher sensor.
//    cnt<=cnt-1; if cnt==1, state<=TRACK.
//    LOCK therefore lasts exactly DWELL edges after the load edge.
//  - TRACK, m=0:
//    - any=0: state<=IDLE, sel<=0.
//    - win!=sel: sel<=win; cnt<=DWELL and state<=LOCK (or stay in TRACK if DWELL=0).
//    - otherwise hold.
//  - y <= cmd slice of the NEXT sel value at the same edge. y is a one-cycle
//    registered copy of the live command; it follows cmd changes on the held channel.
//  - valid <= (next state is LOCK or TRACK); ovr <= (next state is OVR).
//    In IDLE/OVR, y carries channel 0 (cmd[W-1:0]).
//  - en=0: state, sel, cnt, y, valid, ovr all hold their values. cmd/s changes are ignored.
//  - Simultaneous m and sensor edges: m wins. On m falling, arbitration restarts
//    from the OVR rules (a fresh hold is loaded).
//  - cnt width: $clog2(DWELL+1), minimum 1. No wrap: cnt is loaded only on a winner change.
// TESTING  (NCH=16, W=2, DWELL=4; cmd[2k+1:2k]=k[1:0] unless stated)
//  1 Reset: rst_n=0 for 2 edges, random s/m/cmd -> y=0, sel=0, valid=0, ovr=0.
//  2 Priority: s=16'h0024 one edge -> sel=5, y=cmd[11:10]=2'b01, valid=1.
//  3 Dwell hold: s=16'h0004 at edge t0, then s=16'h8000 from t1
//    -> sel=2 at edges t0..t4, sel=15 with y=2'b11 at t5.
//  4 Override: m=1 mid-LOCK -> next edge sel=0, ovr=1, valid=0, y=cmd[1:0].
//    Then m=0 with s=16'h0100 -> next edge sel=8, valid=1, LOCK reloaded.
//  5 Drop/track: in TRACK set s=0 -> next edge IDLE, valid=0, y=cmd[1:0].
//    Change cmd[5:4] while sel=2 in TRACK -> y follows one edge later.
//  6 Freeze/reset: en=0 for 3 edges while toggling s and m -> all outputs unchanged.
//    rst_n=0 mid-LOCK -> reset values next edge, no residual hold.

Source files
------------

// File: rtl/sensor_prio_selector.sv
// sensor_prio_selector: registered highest-index-sensor command selector with dwell hold and master override
module sensor_prio_selector #(
  parameter int NCH = 16,
  parameter int W = 2,
  parameter int DWELL = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            m,
  input  logic [NCH*W-1:0] cmd,
  input  logic [NCH-1:0]  s,
  output logic [W-1:0]    y,
  output logic [CW-1:0]   sel,
  output logic            valid,
  output logic            ovr
);
  localparam int CNTW = DWELL > 0 ? $clog2(DWELL + 1) : 1;
  typedef enum logic [1:0] {IDLE, LOCK, TRACK, OVR} state_t;
  state_t st, nst;
  logic [CW-1:0] win, nsel;
  logic [CNTW-1:0] cnt, ncnt;
  logic any;
  assign any = |s;
  always_comb begin
    win = '0;
    for (int k = 0; k < NCH; k++) win = s[k] ? CW'(k) : win;
  end
  always_comb begin
    nst = st;
    nsel = sel;
    ncnt = cnt;
    if (m) begin
      nst = OVR;
      nsel = '0;
      ncnt = '0;
    end else if (st == LOCK) begin
      ncnt = cnt - 1'b1;
      nst = cnt == CNTW'(1) ? TRACK : LOCK;
    end else if (!any) begin
      nst = IDLE;
      nsel = '0;
    end else if (st != TRACK || win != sel) begin
      nsel = win;
      ncnt = CNTW'(DWELL);
      nst = DWELL > 0 ? LOCK : TRACK;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      sel <= '0;
      cnt <= '0;
      y <= '0;
      valid <= 1'b0;
      ovr <= 1'b0;
    end else if (en) begin
      st <= nst;
      sel <= nsel;
      cnt <= ncnt;
      y <= cmd[W*int'(nsel) +: W];
      valid <= (nst == LOCK) || (nst == TRACK);
      ovr <= nst == OVR;
    end
  end
endmodule

// File: tb/tb_sensor_prio_selector.sv
// tb_sensor_prio_selector: directed checks plus per-cycle comparison against a behavioural model
module tb_sensor_prio_selector;
  localparam int NCH = 16;
  localparam int W = 2;
  localparam int DWELL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic m = 1'b0;
  logic [NCH*W-1:0] cmd;
  logic [NCH-1:0] s = '0;
  logic [W-1:0] y;
  logic [3:0] sel;
  logic valid, ovr;
  int n_chk = 0;
  int n_fail = 0;
  int ch = 0;
  int hold = 0;
  bit act = 0;
  bit ov = 0;
  bit started = 0;
  logic [W-1:0] ym = '0;
  always #5 clk = ~clk;
  sensor_prio_selector #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .m(m), .cmd(cmd), .s(s),
    .y(y), .sel(sel), .valid(valid), .ovr(ovr)
  );
  function automatic logic [NCH*W-1:0] def_cmd();
    logic [NCH*W-1:0] c;
    for (int k = 0; k < NCH; k++) c[k*W +: W] = W'(k);
    return c;
  endfunction
  function automatic int top_bit(logic [NCH-1:0] v);
    int r = -1;
    for (int k = 0; k < NCH; k++) if (v[k]) r = k;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act_v, logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act_v, exp_v);
    end
  endtask
  always @(posedge clk) begin
    int w;
    w = top_bit(s);
    started = 1;
    if (!rst_n) begin
      ch = 0; hold = 0; act = 0; ov = 0; ym = '0;
    end else if (en) begin
      if (m) begin
        ov = 1; act = 0; ch = 0; hold = 0;
      end else if (hold > 0) begin
        hold--;
      end else begin
        ov = 0;
        if (w < 0) begin
          act = 0; ch = 0;
        end else if (!act || w != ch) begin
          ch = w; hold = DWELL; act = 1;
        end
      end
      ym = cmd[ch*W +: W];
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("model_y", 32'(y), 32'(ym));
      chk("model_sel", 32'(sel), 32'(ch));
      chk("model_valid", 32'(valid), 32'(act));
      chk("model_ovr", 32'(ovr), 32'(ov));
    end
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cmd = 32'($urandom);
    s = 16'($urandom);
    m = 1'($urandom);
    rst_n = 1'b0;
    step(2);
    chk("rst_y", 32'(y), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ovr", 32'(ovr), 0);
    cmd = def_cmd();
    m = 0;
    s = '0;
    rst_n = 1'b1;
    step(1);
    s = 16'h0024;
    step(1);
    chk("prio_sel", 32'(sel), 5);
    chk("prio_y", 32'(y), 1);
    chk("prio_valid", 32'(valid), 1);
    s = '0;
    step(6);
    chk("idle_valid", 32'(valid), 0);
    s = 16'h0004;
    step(1);
    chk("dwell_sel_t0", 32'(sel), 2);
    s = 16'h8000;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("dwell_sel_t%0d", i), 32'(sel), 2);
    end
    step(1);
    chk("dwell_sel_t5", 32'(sel), 15);
    chk("dwell_y_t5", 32'(y), 3);
    step(1);
    m = 1;
    step(1);
    chk("ovr_sel", 32'(sel), 0);
    chk("ovr_ovr", 32'(ovr), 1);
    chk("ovr_valid", 32'(valid), 0);
    chk("ovr_y", 32'(y), 0);
    m = 0;
    s = 16'h0100;
    step(1);
    chk("ovr_rel_sel", 32'(sel), 8);
    chk("ovr_rel_valid", 32'(valid), 1);
    chk("ovr_rel_ovr", 32'(ovr), 0);
    s = 16'h8000;
    step(4);
    chk("ovr_reload_sel", 32'(sel), 8);
    step(1);
    chk("ovr_after_sel", 32'(sel), 15);
    s = 16'h0004;
    step(4);
    chk("track15_sel", 32'(sel), 15);
    step(1);
    chk("to2_sel", 32'(sel), 2);
    step(4);
    chk("track2_y", 32'(y), 2);
    cmd[5:4] = 2'b01;
    step(1);
    chk("track_follow_y", 32'(y), 1);
    chk("track_follow_sel", 32'(sel), 2);
    s = '0;
    step(1);
    chk("drop_valid", 32'(valid), 0);
    chk("drop_sel", 32'(sel), 0);
    chk("drop_y", 32'(y), 0);
    cmd = def_cmd();
    s = 16'h0002;
    step(1);
    chk("lock1_sel", 32'(sel), 1);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      s = 16'(16'h8000 >> i);
      m = 1'(i);
      step(1);
      chk("frz_y", 32'(y), 1);
      chk("frz_sel", 32'(sel), 1);
      chk("frz_valid", 32'(valid), 1);
      chk("frz_ovr", 32'(ovr), 0);
    end
    en = 1;
    m = 0;
    s = 16'h0002;
    step(1);
    rst_n = 0;
    step(1);
    chk("rst2_sel", 32'(sel), 0);
    chk("rst2_valid", 32'(valid), 0);
    chk("rst2_y", 32'(y), 0);
    rst_n = 1;
    s = 16'h8000;
    step(1);
    chk("nohold_sel", 32'(sel), 15);
    chk("nohold_valid", 32'(valid), 1);
    for (int i = 0; i < 60; i++) begin
      s = 16'($urandom) & 16'($urandom) & 16'($urandom);
      m = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 7) != 0);
      cmd = 32'($urandom);
      step(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
